// File: rtl/tcm_lsu.sv
// tcm_lsu: load/store unit between the core memory stage and a TCM data port.
// Converts byte-addressed RISC-V loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into
// TCM word accesses; word-crossing misaligned accesses are split into two beats.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_req / o_ready       request handshake (o_ready high only when idle)
//   i_addr, i_we,
//   i_funct3, i_wdata     access description, store data right-aligned
//   o_rvalid, o_rdata     load result pulse and aligned/extended data
//   o_err                 pulse for a rejected access
//   o_tcm_addr,
//   o_tcm_write,
//   o_tcm_data            TCM word address, byte-write enables, write data
//   i_tcm_data            TCM read data, one cycle after o_tcm_addr
module tcm_lsu #(
   parameter int unsigned MEM_ADDR_WIDTH     = 8,
   parameter bit          SUPPORT_MISALIGNED = 1'b1
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_req,
   output logic                      o_ready,
   input  logic [31:0]               i_addr,
   input  logic                      i_we,
   input  logic [2:0]                i_funct3,
   input  logic [31:0]               i_wdata,
   output logic                      o_rvalid,
   output logic [31:0]               o_rdata,
   output logic                      o_err,
   output logic [MEM_ADDR_WIDTH-1:0] o_tcm_addr,
   output logic [3:0]                o_tcm_write,
   output logic [31:0]               o_tcm_data,
   input  logic [31:0]               i_tcm_data
);

   typedef enum logic [1:0] {StIdle, StIssue0, StIssue1, StCollect} state_e;

   state_e r_state, w_state_d;

   // Latched request
   logic [1:0]                r_off;
   logic [MEM_ADDR_WIDTH-1:0] r_wa;
   logic                      r_we;
   logic [2:0]                r_funct3;
   logic                      r_cross;
   logic [3:0]                r_b1_write;
   logic [31:0]               r_b1_data;
   logic [31:0]               r_lo;

   // Registered outputs
   logic [MEM_ADDR_WIDTH-1:0] r_tcm_addr;
   logic [3:0]                r_tcm_write;
   logic [31:0]               r_tcm_data;
   logic [31:0]               r_rdata;
   logic                      r_rvalid;
   logic                      r_err;

   // Request decode
   logic [1:0]  w_off;
   logic [1:0]  w_size;
   logic        w_accept, w_cross, w_misal, w_bad, w_start;
   logic [3:0]  w_base_mask;
   logic [31:0] w_wdata_sized;
   logic [7:0]  w_m8;
   logic [63:0] w_d64;
   logic        w_unused_addr;

   // Load return path
   logic [31:0] w_lo, w_hi;
   logic [63:0] w_pair;
   logic [31:0] w_rdata;

   assign w_off         = i_addr[1:0];
   assign w_size        = i_funct3[1:0];
   assign w_accept      = i_req && (r_state == StIdle);
   assign w_cross       = ((w_size == 2'b01) && (w_off == 2'b11)) ||
                          ((w_size == 2'b10) && (w_off != 2'b00));
   assign w_misal       = ((w_size == 2'b01) && w_off[0]) ||
                          ((w_size == 2'b10) && (w_off != 2'b00));
   assign w_bad         = (w_size == 2'b11) || (w_misal && !SUPPORT_MISALIGNED);
   assign w_start       = w_accept && !w_bad;
   assign w_unused_addr = ^i_addr[31:MEM_ADDR_WIDTH+2];

   // Store lanes: an 8-byte window so beat 1 of a split store falls out of [7:4]/[63:32]
   always_comb begin
      w_base_mask   = 4'b1111;
      w_wdata_sized = i_wdata;
      case (w_size)
         2'b00: begin
            w_base_mask   = 4'b0001;
            w_wdata_sized = {24'h0, i_wdata[7:0]};
         end
         2'b01: begin
            w_base_mask   = 4'b0011;
            w_wdata_sized = {16'h0, i_wdata[15:0]};
         end
         default: ;
      endcase
      w_m8  = {4'b0000, w_base_mask} << w_off;
      w_d64 = {32'h0, w_wdata_sized} << {w_off, 3'b000};
   end

   // In COLLECT the current TCM word is the high half only for a split access
   assign w_lo = r_cross ? r_lo : i_tcm_data;
   assign w_hi = r_cross ? i_tcm_data : 32'h0;

   always_comb begin
      w_pair  = {w_hi, w_lo} >> {r_off, 3'b000};
      w_rdata = w_pair[31:0];
      case (r_funct3[1:0])
         2'b00:   w_rdata = {{24{~r_funct3[2] & w_pair[7]}}, w_pair[7:0]};
         2'b01:   w_rdata = {{16{~r_funct3[2] & w_pair[15]}}, w_pair[15:0]};
         default: ;
      endcase
   end

   always_comb begin
      w_state_d = r_state;
      case (r_state)
         StIdle:    if (w_start) w_state_d = StIssue0;
         StIssue0: begin
            if (r_cross)   w_state_d = StIssue1;
            else if (r_we) w_state_d = StIdle;
            else           w_state_d = StCollect;
         end
         StIssue1:  w_state_d = r_we ? StIdle : StCollect;
         StCollect: w_state_d = StIdle;
         default:   w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= StIdle;
      else         r_state <= w_state_d;
   end

   // TCM outputs are loaded on entry to the beat they describe, so they are
   // valid for the whole ISSUE0/ISSUE1 cycle.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_off       <= 2'b00;
         r_wa        <= '0;
         r_we        <= 1'b0;
         r_funct3    <= 3'b000;
         r_cross     <= 1'b0;
         r_b1_write  <= 4'h0;
         r_b1_data   <= 32'h0;
         r_lo        <= 32'h0;
         r_tcm_addr  <= '0;
         r_tcm_write <= 4'h0;
         r_tcm_data  <= 32'h0;
         r_rdata     <= 32'h0;
         r_rvalid    <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_rvalid    <= 1'b0;
         r_err       <= w_accept && w_bad;
         r_tcm_write <= 4'h0;
         if (w_start) begin
            r_off      <= w_off;
            r_wa       <= i_addr[MEM_ADDR_WIDTH+1:2];
            r_we       <= i_we;
            r_funct3   <= i_funct3;
            r_cross    <= w_cross;
            r_b1_write <= w_m8[7:4];
            r_b1_data  <= w_d64[63:32];
            r_tcm_addr <= i_addr[MEM_ADDR_WIDTH+1:2];
            if (i_we) begin
               r_tcm_write <= w_m8[3:0];
               r_tcm_data  <= w_d64[31:0];
            end
         end
         case (r_state)
            StIssue0: begin
               if (r_cross) begin
                  r_tcm_addr <= r_wa + MEM_ADDR_WIDTH'(1);
                  if (r_we) begin
                     r_tcm_write <= r_b1_write;
                     r_tcm_data  <= r_b1_data;
                  end
               end
            end
            StIssue1:  r_lo <= i_tcm_data;
            StCollect: begin
               r_rdata  <= w_rdata;
               r_rvalid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign o_ready     = (r_state == StIdle);
   assign o_rvalid    = r_rvalid;
   assign o_rdata     = r_rdata;
   assign o_err       = r_err;
   assign o_tcm_addr  = r_tcm_addr;
   assign o_tcm_write = r_tcm_write;
   assign o_tcm_data  = r_tcm_data;

endmodule

// File: tb/tb_tcm_lsu.sv
// Testbench for tcm_lsu: scoreboard of expected responses checked by a monitor,
// byte-addressed reference memory, directed timing cases plus random traffic.
module tb_tcm_lsu;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // Main DUT (misaligned support on)
   logic        i_reset, i_req, i_we;
   logic [31:0] i_addr, i_wdata;
   logic [2:0]  i_funct3;
   logic        o_ready, o_rvalid, o_err;
   logic [31:0] o_rdata, o_tcm_data, tcm_rdata;
   logic [7:0]  o_tcm_addr;
   logic [3:0]  o_tcm_write;

   // Second DUT (misaligned support off)
   logic        n_req, n_we;
   logic [31:0] n_addr, n_wdata;
   logic [2:0]  n_funct3;
   logic        n_ready, n_rvalid, n_err;
   logic [31:0] n_rdata, n_tcm_data;
   logic [31:0] n_tcm_rdata = 32'h0;
   logic [7:0]  n_tcm_addr;
   logic [3:0]  n_tcm_write;

   tcm_lsu #(.MEM_ADDR_WIDTH(8), .SUPPORT_MISALIGNED(1'b1)) u_dut (
      .i_clk(clk), .i_reset(i_reset), .i_req(i_req), .o_ready(o_ready),
      .i_addr(i_addr), .i_we(i_we), .i_funct3(i_funct3), .i_wdata(i_wdata),
      .o_rvalid(o_rvalid), .o_rdata(o_rdata), .o_err(o_err),
      .o_tcm_addr(o_tcm_addr), .o_tcm_write(o_tcm_write), .o_tcm_data(o_tcm_data),
      .i_tcm_data(tcm_rdata)
   );

   tcm_lsu #(.MEM_ADDR_WIDTH(8), .SUPPORT_MISALIGNED(1'b0)) u_dut_nm (
      .i_clk(clk), .i_reset(i_reset), .i_req(n_req), .o_ready(n_ready),
      .i_addr(n_addr), .i_we(n_we), .i_funct3(n_funct3), .i_wdata(n_wdata),
      .o_rvalid(n_rvalid), .o_rdata(n_rdata), .o_err(n_err),
      .o_tcm_addr(n_tcm_addr), .o_tcm_write(n_tcm_write), .o_tcm_data(n_tcm_data),
      .i_tcm_data(n_tcm_rdata)
   );

   // TCM behaviour: synchronous read (old data), byte-enabled write
   logic [31:0] mem [256];
   always @(posedge clk) begin
      tcm_rdata <= mem[o_tcm_addr];
      for (int k = 0; k < 4; k++)
         if (o_tcm_write[k]) mem[o_tcm_addr][8*k +: 8] = o_tcm_data[8*k +: 8];
   end

   // Reference: flat little-endian byte space of 1024 bytes
   logic [7:0] ref_mem [1024];

   typedef struct packed {
      logic        err;
      logic [31:0] data;
   } exp_t;
   exp_t exp_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic set_word(input int idx, input logic [31:0] v);
      mem[idx] = v;
      for (int k = 0; k < 4; k++) ref_mem[idx*4 + k] = v[8*k +: 8];
   endtask

   // Response monitor
   always @(negedge clk) begin
      if (!i_reset && (o_rvalid || o_err)) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_response: rvalid=%0b err=%0b, expected none",
                     o_rvalid, o_err);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("resp_kind", {30'h0, o_err, o_rvalid}, {30'h0, e.err, ~e.err});
            if (!e.err) check("load_data", o_rdata, e.data);
         end
      end
   end

   // Wait for o_ready, then issue one request and record its expected outcome.
   // Returns just after the accepting edge (cycle N+1 begins).
   task automatic issue(input logic [31:0] a, input logic we, input logic [2:0] f3,
                        input logic [31:0] wd);
      int   g;
      int   n;
      logic [31:0] v;
      exp_t e;
      g = 0;
      @(negedge clk);
      while (!o_ready && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (g >= 100) begin
         n_tests++;
         n_fail++;
         $display("FAIL ready_timeout: o_ready=%0b, expected 1", o_ready);
      end
      i_req = 1'b1; i_addr = a; i_we = we; i_funct3 = f3; i_wdata = wd;
      n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      if (f3[1:0] == 2'b11) begin
         e.err = 1'b1; e.data = 32'h0;
         exp_q.push_back(e);
      end else if (we) begin
         for (int k = 0; k < n; k++) ref_mem[(a[9:0] + k) % 1024] = wd[8*k +: 8];
      end else begin
         v = 32'h0;
         for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[(a[9:0] + k) % 1024];
         if (!f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
         if (!f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
         e.err = 1'b0; e.data = v;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1 i_req = 1'b0;
   endtask

   initial begin
      logic [31:0] a, wd, ew;
      logic [2:0]  f3;
      int          r, g;
      i_reset = 1'b1; i_req = 1'b0; i_addr = 0; i_we = 0; i_funct3 = 0; i_wdata = 0;
      n_req = 1'b0; n_addr = 0; n_we = 0; n_funct3 = 0; n_wdata = 0;
      for (int w = 0; w < 256; w++) set_word(w, $urandom);
      repeat (3) @(negedge clk);
      i_reset = 1'b0;
      @(negedge clk);

      // Reset state
      check("rst_ready", {31'h0, o_ready}, 32'h1);
      check("rst_rvalid", {31'h0, o_rvalid}, 32'h0);
      check("rst_err", {31'h0, o_err}, 32'h0);
      check("rst_rdata", o_rdata, 32'h0);
      check("rst_tcm_addr", {24'h0, o_tcm_addr}, 32'h0);
      check("rst_tcm_write", {28'h0, o_tcm_write}, 32'h0);
      check("rst_tcm_data", o_tcm_data, 32'h0);

      // Aligned LW: address in N+1, result in N+3
      set_word(4, 32'hDEADBEEF);
      issue(32'h10, 1'b0, 3'b010, 32'h0);
      @(negedge clk);
      check("lw_addr", {24'h0, o_tcm_addr}, 32'd4);
      check("lw_write", {28'h0, o_tcm_write}, 32'h0);
      @(negedge clk);
      check("lw_no_early_rvalid", {31'h0, o_rvalid}, 32'h0);
      @(negedge clk);
      check("lw_rvalid_n3", {31'h0, o_rvalid}, 32'h1);
      check("lw_rdata", o_rdata, 32'hDEADBEEF);
      check("lw_ready_n3", {31'h0, o_ready}, 32'h1);

      // Byte/half extension
      set_word(4, 32'h80112233);
      issue(32'h13, 1'b0, 3'b000, 32'h0);
      issue(32'h13, 1'b0, 3'b100, 32'h0);
      issue(32'h12, 1'b0, 3'b101, 32'h0);
      issue(32'h12, 1'b0, 3'b001, 32'h0);

      // SH single beat
      issue(32'h12, 1'b1, 3'b001, 32'h55551234);
      @(negedge clk);
      check("sh_addr", {24'h0, o_tcm_addr}, 32'd4);
      check("sh_write", {28'h0, o_tcm_write}, 32'hC);
      check("sh_data", o_tcm_data, 32'h12340000);
      @(negedge clk);
      check("sh_ready_n2", {31'h0, o_ready}, 32'h1);
      check("sh_write_off", {28'h0, o_tcm_write}, 32'h0);

      // Split SW
      issue(32'h11, 1'b1, 3'b010, 32'hAABBCCDD);
      @(negedge clk);
      check("sw0_addr", {24'h0, o_tcm_addr}, 32'd4);
      check("sw0_write", {28'h0, o_tcm_write}, 32'hE);
      check("sw0_data", o_tcm_data, 32'hBBCCDD00);
      check("sw0_not_ready", {31'h0, o_ready}, 32'h0);
      @(negedge clk);
      check("sw1_addr", {24'h0, o_tcm_addr}, 32'd5);
      check("sw1_write", {28'h0, o_tcm_write}, 32'h1);
      check("sw1_data", o_tcm_data, 32'h000000AA);
      @(negedge clk);
      check("sw_ready_n3", {31'h0, o_ready}, 32'h1);
      issue(32'h11, 1'b0, 3'b010, 32'h0);

      // Crossing LW with word-address wrap
      set_word(255, 32'h44332211);
      set_word(0, 32'h88776655);
      issue(32'h3FE, 1'b0, 3'b010, 32'h0);
      @(negedge clk);
      check("wrap_addr0", {24'h0, o_tcm_addr}, 32'd255);
      @(negedge clk);
      check("wrap_addr1", {24'h0, o_tcm_addr}, 32'd0);
      @(negedge clk);
      check("wrap_no_rvalid_n3", {31'h0, o_rvalid}, 32'h0);
      @(negedge clk);
      check("wrap_rvalid_n4", {31'h0, o_rvalid}, 32'h1);
      check("wrap_rdata", o_rdata, 32'h66554433);

      // Size 11 rejected
      issue(32'h40, 1'b0, 3'b011, 32'h0);
      @(negedge clk);
      check("bad_size_err", {31'h0, o_err}, 32'h1);
      check("bad_size_ready", {31'h0, o_ready}, 32'h1);
      check("bad_size_write", {28'h0, o_tcm_write}, 32'h0);

      // Misalignment rejected when unsupported
      n_req = 1'b1; n_addr = 32'h21; n_we = 1'b0; n_funct3 = 3'b001;
      @(posedge clk);
      #1 n_req = 1'b0;
      @(negedge clk);
      check("nm_err", {31'h0, n_err}, 32'h1);
      check("nm_ready", {31'h0, n_ready}, 32'h1);
      check("nm_write", {28'h0, n_tcm_write}, 32'h0);
      repeat (3) begin
         @(negedge clk);
         check("nm_no_rvalid", {30'h0, n_rvalid, n_err}, 32'h0);
      end
      n_req = 1'b1; n_addr = 32'h20; n_we = 1'b1; n_funct3 = 3'b010; n_wdata = 32'h12345678;
      @(posedge clk);
      #1 n_req = 1'b0;
      @(negedge clk);
      check("nm_sw_err", {31'h0, n_err}, 32'h0);
      check("nm_sw_write", {28'h0, n_tcm_write}, 32'hF);
      check("nm_sw_data", n_tcm_data, 32'h12345678);

      // Reset during beat 0 of a split store: beat 1 is dropped
      g = 0;
      @(negedge clk);
      while (!o_ready && g < 100) begin
         @(negedge clk);
         g++;
      end
      i_req = 1'b1; i_addr = 32'h21; i_we = 1'b1; i_funct3 = 3'b010; i_wdata = 32'h11223344;
      @(posedge clk);
      #1 i_req = 1'b0;
      @(negedge clk);
      check("rst_mid_beat0", {28'h0, o_tcm_write}, 32'hE);
      i_reset = 1'b1;
      ref_mem[32'h21] = 8'h44; ref_mem[32'h22] = 8'h33; ref_mem[32'h23] = 8'h22;
      @(negedge clk);
      check("rst_mid_write", {28'h0, o_tcm_write}, 32'h0);
      check("rst_mid_ready", {31'h0, o_ready}, 32'h1);
      i_reset = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("rst_mid_no_beat1", {28'h0, o_tcm_write}, 32'h0);
      end

      // Random traffic
      for (int t = 0; t < 400; t++) begin
         a  = $urandom;
         wd = $urandom;
         r  = $urandom_range(0, 15);
         f3[1:0] = (r < 5) ? 2'b00 : (r < 10) ? 2'b01 : (r < 15) ? 2'b10 : 2'b11;
         f3[2]   = 1'($urandom_range(0, 1));
         issue(a, 1'($urandom_range(0, 1)), f3, wd);
      end

      // Drain outstanding responses and the last store
      g = 0;
      while ((exp_q.size() != 0 || !o_ready) && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (g >= 50) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_timeout: %0d responses pending, expected 0", exp_q.size());
      end
      @(negedge clk);

      for (int w = 0; w < 256; w++) begin
         for (int k = 0; k < 4; k++) ew[8*k +: 8] = ref_mem[w*4 + k];
         check("mem_word", mem[w], ew);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
